tdm_demux: RTL and testbench

- Time-division demultiplexer: the receiving end of a time-multiplexed serial line built from a select counter and a mux.
- Each qualified sample of the 1-bit input is routed to output slot N, where N is an internal slot counter that restarts on a frame sync marker.
- When all slots of a frame are received, the frame is transferred to a registered parallel output with a one-cycle valid pulse.
- Used behind board switches/keys (SW/KEY) feeding LEDR, or behind a serializer elsewhere in the lab designs.

---
 rtl/tdm_demux_pkg.sv | 12 +
 rtl/tdm_slot_counter.sv | 32 +++
 rtl/tdm_demux.sv | 124 ++++++++++++
 tb/tb_tdm_demux.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state encoding and default geometry.
package tdm_demux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot select counter: load-to-1 on frame start, increment per sample, clear on completion.
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load1,
    input  logic             inc,
    input  logic             clear,
    output logic [SEL_W-1:0] count,
    output logic             terminal
);

    // load1 wins so a sync always restarts at slot 1, even over a completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load1) begin
            count <= SEL_W'(1);
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + SEL_W'(1);
        end
    end

    assign terminal = (count == SEL_W'(WIDTH - 1));

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: routes qualified serial samples into frame slots and
// publishes each complete frame on a registered parallel output with a valid pulse.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             data_in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [SEL_W-1:0] slot,
    output logic             busy,
    output logic             frame_err
);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-2:0]   shadow;
    logic [WIDTH-2:0]   shadow_we;
    logic [SEL_W-1:0]   wr_idx;
    logic               wr_en;
    logic               cnt_load1;
    logic               cnt_inc;
    logic               cnt_clear;
    logic               cnt_terminal;
    logic               deliver;
    logic               err;

    tdm_slot_counter #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clock    (clock),
        .reset    (reset),
        .load1    (cnt_load1),
        .inc      (cnt_inc),
        .clear    (cnt_clear),
        .count    (slot),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A sync in RECV (including on the last slot) abandons the frame and restarts it.
    always_comb begin
        state_next = state;
        cnt_load1  = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clear  = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        deliver    = 1'b0;
        err        = 1'b0;
        if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (sync) begin
                        wr_en      = 1'b1;
                        cnt_load1  = 1'b1;
                        state_next = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (sync) begin
                        err       = 1'b1;
                        wr_en     = 1'b1;
                        cnt_load1 = 1'b1;
                    end else if (cnt_terminal) begin
                        deliver    = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = slot;
                        cnt_inc = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shadow_we = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            shadow_we[i] = wr_en && (wr_idx == SEL_W'(i));
        end
    end

    // The final slot bypasses the shadow and lands directly in out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (shadow_we[i]) begin
                    shadow[i] <= data_in;
                end
            end
            if (deliver) begin
                out <= {data_in, shadow};
            end
            out_valid <= deliver;
            frame_err <= err;
        end
    end

    assign busy = (state == ST_RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: scoreboard of expected frames checked on each out_valid.
module tb_tdm_demux;

    localparam int W = 8;
    localparam int S = 3;

    logic         clock;
    logic         reset;
    logic         enable;
    logic         sync;
    logic         data_in;
    logic [W-1:0] out;
    logic         out_valid;
    logic [S-1:0] slot;
    logic         busy;
    logic         frame_err;

    logic [W-1:0] exp_q[$];
    int           n_compared;
    int           n_mismatched;

    tdm_demux #(
        .WIDTH (W),
        .SEL_W (S)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sync      (sync),
        .data_in   (data_in),
        .out       (out),
        .out_valid (out_valid),
        .slot      (slot),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic sy, input logic d);
        @(negedge clock);
        enable  = en;
        sync    = sy;
        data_in = d;
        @(posedge clock);
        #1;
    endtask

    // Sends bits first..last of frame f (slot 0 carries sync); gap idle cycles follow each sample.
    task automatic send_samples(input logic [W-1:0] f, input int first, input int last,
                                input int gap, input bit deliver);
        for (int i = first; i <= last; i++) begin
            if (deliver && i == last) exp_q.push_back(f);
            drive(1'b1, (i == 0), f[i]);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if (i < W - 1) check("gap_slot", 32'(slot), 32'(i + 1));
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 32'(0));
                end else begin
                    check("frame_out", 32'(out), 32'(exp_q.pop_front()));
                end
                check("valid_err_exclusive", 32'(frame_err), 32'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] rf;
        n_compared   = 0;
        n_mismatched = 0;
        enable  = 1'b0;
        sync    = 1'b0;
        data_in = 1'b0;
        reset   = 1'b1;
        #3;
        check("rst_out", 32'(out), 32'(0));
        check("rst_slot", 32'(slot), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_err", 32'(frame_err), 32'(0));
        @(negedge clock);
        reset = 1'b0;

        // Nominal 0xA5 frame
        send_samples(8'hA5, 0, W - 1, 0, 1'b1);
        check("nom_valid", 32'(out_valid), 32'(1));
        check("nom_out", 32'(out), 32'hA5);
        check("nom_busy", 32'(busy), 32'(0));
        check("nom_slot", 32'(slot), 32'(0));
        drive(1'b0, 1'b0, 1'b0);
        check("nom_valid_pulse", 32'(out_valid), 32'(0));
        check("nom_out_hold", 32'(out), 32'hA5);

        // Gapped enable, same frame
        send_samples(8'hA5, 0, W - 1, 3, 1'b1);
        check("gap_out", 32'(out), 32'hA5);

        // Early sync at slot 4
        send_samples(8'hFF, 0, 3, 0, 1'b0);
        check("early_slot", 32'(slot), 32'(4));
        check("early_busy", 32'(busy), 32'(1));
        send_samples(8'h3C, 0, 0, 0, 1'b0);
        check("early_err", 32'(frame_err), 32'(1));
        check("early_valid", 32'(out_valid), 32'(0));
        check("early_out_hold", 32'(out), 32'hA5);
        check("early_restart_slot", 32'(slot), 32'(1));
        send_samples(8'h3C, 1, W - 1, 0, 1'b1);
        check("early_out", 32'(out), 32'h3C);
        check("early_err_clear", 32'(frame_err), 32'(0));

        // Sync on the last slot counts as early
        send_samples(8'h0F, 0, W - 2, 0, 1'b0);
        check("last_slot", 32'(slot), 32'(W - 1));
        send_samples(8'h96, 0, 0, 0, 1'b0);
        check("last_err", 32'(frame_err), 32'(1));
        check("last_valid", 32'(out_valid), 32'(0));
        check("last_out_hold", 32'(out), 32'h3C);
        send_samples(8'h96, 1, W - 1, 0, 1'b1);
        check("last_out", 32'(out), 32'h96);

        // Idle noise then back-to-back frames
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            check("noise_slot", 32'(slot), 32'(0));
            check("noise_busy", 32'(busy), 32'(0));
        end
        send_samples(8'h81, 0, W - 1, 0, 1'b1);
        check("b2b_first", 32'(out), 32'h81);
        send_samples(8'h7E, 0, W - 2, 0, 1'b0);
        check("b2b_gap_valid", 32'(out_valid), 32'(0));
        send_samples(8'h7E, W - 1, W - 1, 0, 1'b1);
        check("b2b_second", 32'(out), 32'h7E);
        check("b2b_valid", 32'(out_valid), 32'(1));

        // Reset mid-frame
        send_samples(8'hFF, 0, 4, 0, 1'b0);
        check("mid_slot", 32'(slot), 32'(5));
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out", 32'(out), 32'(0));
        check("mid_rst_slot", 32'(slot), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        #1;
        reset = 1'b0;
        send_samples(8'h5A, 0, W - 1, 0, 1'b1);
        check("mid_out", 32'(out), 32'h5A);

        // Random frames with random gaps
        repeat (4) begin
            rf = W'($urandom_range(0, 255));
            send_samples(rf, 0, W - 1, $urandom_range(0, 2), 1'b1);
            check("rand_out", 32'(out), 32'(rf));
        end

        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
